// File: rtl/reg_universal_pkg.sv
// Shared CTRL codes, FSM state type and burst-eligibility helper for reg_universal_seq.
// Honours REG_UNIVERSAL_ROTATE_EN: rotates are burst-capable only when it is defined.
package reg_universal_pkg;

  localparam logic [2:0] CTRL_HOLD = 3'b000;
  localparam logic [2:0] CTRL_SHL  = 3'b001;
  localparam logic [2:0] CTRL_LOAD = 3'b010;
  localparam logic [2:0] CTRL_SHR  = 3'b011;
  localparam logic [2:0] CTRL_ASR  = 3'b100;
  localparam logic [2:0] CTRL_ROL  = 3'b101;
  localparam logic [2:0] CTRL_ROR  = 3'b110;
  localparam logic [2:0] CTRL_CLR  = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_FINISH = 2'd2
  } state_t;

  function automatic logic is_burst_op(input logic [2:0] op);
    logic ok;
    ok = (op == CTRL_SHL) || (op == CTRL_SHR) || (op == CTRL_ASR);
`ifdef REG_UNIVERSAL_ROTATE_EN
    ok = ok || (op == CTRL_ROL) || (op == CTRL_ROR);
`endif
    return ok;
  endfunction

endpackage

// File: rtl/reg_universal_mux.sv
// Next-value multiplexer for the universal register (shift/load/rotate/clear).
// Rotates exist only with REG_UNIVERSAL_ROTATE_EN; otherwise 101/110 hold.
module reg_universal_mux
  import reg_universal_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] q,
  input  logic [2:0]       op,
  input  logic             s_in,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q_next
);

  always_comb begin
    q_next = q;
    case (op)
      CTRL_SHL:  q_next = {q[WIDTH-2:0], s_in};
      CTRL_LOAD: q_next = d;
      CTRL_SHR:  q_next = {s_in, q[WIDTH-1:1]};
      CTRL_ASR:  q_next = {q[WIDTH-1], q[WIDTH-1:1]};
`ifdef REG_UNIVERSAL_ROTATE_EN
      CTRL_ROL:  q_next = {q[WIDTH-2:0], q[WIDTH-1]};
      CTRL_ROR:  q_next = {q[0], q[WIDTH-1:1]};
`endif
      CTRL_CLR:  q_next = '0;
      default:   q_next = q;
    endcase
  end

endmodule

// File: rtl/reg_universal_seq.sv
// Universal shift register with a counted burst sequencer; rotate ops need REG_UNIVERSAL_ROTATE_EN.
// state     | meaning
// ST_IDLE   | CTRL applied per enabled edge; START with a shift/rotate op launches a burst
// ST_RUN    | latched op applied per enabled edge, counter counts down to 0
// ST_FINISH | one-cycle DONE pulse, then back to ST_IDLE
module reg_universal_seq
  import reg_universal_pkg::*;
#(
  parameter  int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             CLOCK,
  input  logic             RESET_N,
  input  logic             ENABLE,
  input  logic [2:0]       CTRL,
  input  logic             S_IN,
  input  logic [WIDTH-1:0] D,
  input  logic             START,
  input  logic [CNT_W-1:0] LEN,
  output logic [WIDTH-1:0] Q,
  output logic             S_OUT_L,
  output logic             S_OUT_R,
  output logic             BUSY,
  output logic             DONE
);

  state_t           state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic [2:0]       op_lat, op_next;
  logic [2:0]       mux_op;
  logic [WIDTH-1:0] mux_q, q_upd;

  // During a burst the latched op drives the mux so CTRL changes are ignored.
  assign mux_op = (state == ST_RUN) ? op_lat : CTRL;

  reg_universal_mux #(.WIDTH(WIDTH)) u_mux (
    .q      (Q),
    .op     (mux_op),
    .s_in   (S_IN),
    .d      (D),
    .q_next (mux_q)
  );

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    op_next    = op_lat;
    q_upd      = Q;
    case (state)
      ST_IDLE: begin
        if (START && is_burst_op(CTRL)) begin
          op_next    = CTRL;
          cnt_next   = LEN;
          state_next = (LEN == '0) ? ST_FINISH : ST_RUN;
        end else if (ENABLE) begin
          q_upd = mux_q;
        end
      end
      ST_RUN: begin
        if (ENABLE) begin
          q_upd    = mux_q;
          cnt_next = cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) state_next = ST_FINISH;
        end
      end
      ST_FINISH: state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      state  <= ST_IDLE;
      Q      <= '0;
      cnt    <= '0;
      op_lat <= CTRL_HOLD;
      BUSY   <= 1'b0;
      DONE   <= 1'b0;
    end else begin
      state  <= state_next;
      Q      <= q_upd;
      cnt    <= cnt_next;
      op_lat <= op_next;
      BUSY   <= (state_next == ST_RUN);
      DONE   <= (state_next == ST_FINISH);
    end
  end

  assign S_OUT_L = Q[WIDTH-1];
  assign S_OUT_R = Q[0];

endmodule

// File: tb/tb_reg_universal_seq.sv
// Bench for reg_universal_seq (WIDTH=8): vector table, burst corner sequences, randomized model compare.
// Expectations for rotate cases follow REG_UNIVERSAL_ROTATE_EN when it is defined for the build.
module tb_reg_universal_seq;
  localparam int WIDTH = 8;
  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam int M = 1 << WIDTH;
  localparam int H = M / 2;

  logic             CLOCK = 1'b0;
  logic             RESET_N = 1'b0;
  logic             ENABLE = 1'b0;
  logic [2:0]       CTRL = 3'd0;
  logic             S_IN = 1'b0;
  logic [WIDTH-1:0] D = '0;
  logic             START = 1'b0;
  logic [CNT_W-1:0] LEN = '0;
  logic [WIDTH-1:0] Q;
  logic             S_OUT_L, S_OUT_R, BUSY, DONE;

  reg_universal_seq #(.WIDTH(WIDTH)) dut (
    .CLOCK(CLOCK), .RESET_N(RESET_N), .ENABLE(ENABLE), .CTRL(CTRL), .S_IN(S_IN),
    .D(D), .START(START), .LEN(LEN), .Q(Q), .S_OUT_L(S_OUT_L), .S_OUT_R(S_OUT_R),
    .BUSY(BUSY), .DONE(DONE)
  );

  always #5 CLOCK = ~CLOCK;

  int n_total = 0;
  int n_pass = 0;

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

`ifdef REG_UNIVERSAL_ROTATE_EN
  localparam bit ROT = 1'b1;
`else
  localparam bit ROT = 1'b0;
`endif

  // Reference model: register value as an integer, burst as remaining shift count.
  int m_q, m_remaining, m_op;
  bit m_bursting, m_done_next;

  function automatic int apply_op(input int op, input int q, input int s, input int d);
    case (op)
      1: return ((q * 2) % M) + s;
      2: return d;
      3: return q / 2 + s * H;
      4: return q / 2 + (q / H) * H;
      5: return ROT ? ((q * 2) % M) + q / H : q;
      6: return ROT ? q / 2 + (q % 2) * H : q;
      7: return 0;
      default: return q;
    endcase
  endfunction

  function automatic bit burst_ok(input int op);
    return (op == 1) || (op == 3) || (op == 4) || (ROT && (op == 5 || op == 6));
  endfunction

  task automatic model_reset();
    m_q = 0; m_remaining = 0; m_op = 0; m_bursting = 0; m_done_next = 0;
  endtask

  task automatic model_edge();
    if (m_done_next) begin
      m_done_next = 0;
    end else if (m_bursting) begin
      if (ENABLE) begin
        m_q = apply_op(m_op, m_q, int'(S_IN), 0);
        m_remaining--;
        if (m_remaining == 0) begin m_bursting = 0; m_done_next = 1; end
      end
    end else if (START && burst_ok(int'(CTRL))) begin
      m_op = int'(CTRL);
      m_remaining = int'(LEN);
      if (m_remaining == 0) m_done_next = 1;
      else m_bursting = 1;
    end else if (ENABLE) begin
      m_q = apply_op(int'(CTRL), m_q, int'(S_IN), int'(D));
    end
  endtask

  task automatic check_model(input string name);
    check({name, "_q"}, int'(Q), m_q);
    check({name, "_busy"}, int'(BUSY), int'(m_bursting));
    check({name, "_done"}, int'(DONE), int'(m_done_next));
    check({name, "_sol"}, int'(S_OUT_L), (m_q / H) % 2);
    check({name, "_sor"}, int'(S_OUT_R), m_q % 2);
  endtask

  task automatic drive(input logic [2:0] c, input logic s, input logic [7:0] dd,
                       input logic st, input logic [CNT_W-1:0] l, input logic en);
    CTRL = c; S_IN = s; D = dd; START = st; LEN = l; ENABLE = en;
  endtask

  task automatic step();
    model_edge();
    @(posedge CLOCK);
    #1;
  endtask

  typedef struct {
    logic [2:0] ctrl; logic s_in; logic [7:0] d; logic start; logic [3:0] len; logic en;
    logic [7:0] q; logic busy; logic done;
  } vec_t;

  vec_t tv[16];
  int busy_cnt;

  initial begin
    tv[0]  = '{3'b010, 1'b0, 8'hA5, 1'b0, 4'd0, 1'b1, 8'hA5, 1'b0, 1'b0};
    tv[1]  = '{3'b001, 1'b1, 8'h00, 1'b0, 4'd0, 1'b1, 8'h4B, 1'b0, 1'b0};
    tv[2]  = '{3'b100, 1'b0, 8'h00, 1'b0, 4'd0, 1'b1, 8'h25, 1'b0, 1'b0};
    tv[3]  = '{3'b111, 1'b0, 8'h00, 1'b0, 4'd0, 1'b1, 8'h00, 1'b0, 1'b0};
    tv[4]  = '{3'b010, 1'b0, 8'hF0, 1'b0, 4'd0, 1'b1, 8'hF0, 1'b0, 1'b0};
    tv[5]  = '{3'b010, 1'b0, 8'h00, 1'b0, 4'd0, 1'b0, 8'hF0, 1'b0, 1'b0};
    tv[6]  = '{3'b001, 1'b1, 8'h00, 1'b1, 4'd0, 1'b1, 8'hF0, 1'b0, 1'b1};
    tv[7]  = '{3'b000, 1'b0, 8'h00, 1'b0, 4'd0, 1'b1, 8'hF0, 1'b0, 1'b0};
    tv[8]  = '{3'b010, 1'b0, 8'h3C, 1'b1, 4'd0, 1'b1, 8'h3C, 1'b0, 1'b0};
    tv[9]  = '{3'b001, 1'b0, 8'h00, 1'b1, 4'd2, 1'b1, 8'h3C, 1'b1, 1'b0};
    tv[10] = '{3'b010, 1'b0, 8'hFF, 1'b1, 4'd0, 1'b1, 8'h78, 1'b1, 1'b0};
    tv[11] = '{3'b010, 1'b0, 8'hFF, 1'b1, 4'd5, 1'b1, 8'hF0, 1'b0, 1'b1};
    tv[12] = '{3'b111, 1'b0, 8'hFF, 1'b1, 4'd3, 1'b1, 8'hF0, 1'b0, 1'b0};
    tv[13] = '{3'b011, 1'b1, 8'h00, 1'b1, 4'd1, 1'b0, 8'hF0, 1'b1, 1'b0};
    tv[14] = '{3'b011, 1'b1, 8'h00, 1'b0, 4'd0, 1'b1, 8'hF8, 1'b0, 1'b1};
    tv[15] = '{3'b000, 1'b0, 8'h00, 1'b0, 4'd0, 1'b1, 8'hF8, 1'b0, 1'b0};

    #2;
    check("reset_q", int'(Q), 0);
    check("reset_busy", int'(BUSY), 0);
    check("reset_done", int'(DONE), 0);
    model_reset();
    @(negedge CLOCK);
    RESET_N = 1'b1;

    for (int i = 0; i < 16; i++) begin
      drive(tv[i].ctrl, tv[i].s_in, tv[i].d, tv[i].start, tv[i].len, tv[i].en);
      step();
      check($sformatf("vec%0d_q", i), int'(Q), int'(tv[i].q));
      check($sformatf("vec%0d_busy", i), int'(BUSY), int'(tv[i].busy));
      check($sformatf("vec%0d_done", i), int'(DONE), int'(tv[i].done));
    end

    // Burst with two paused cycles in the middle.
    drive(3'b010, 1'b0, 8'hF0, 1'b0, '0, 1'b1); step();
    drive(3'b011, 1'b0, 8'h00, 1'b1, 4'd4, 1'b1); step();
    busy_cnt = int'(BUSY);
    for (int i = 0; i < 6; i++) begin
      drive(3'b111, 1'b0, 8'hFF, 1'b0, '0, (i == 2 || i == 3) ? 1'b0 : 1'b1);
      step();
      check_model("pause");
      busy_cnt += int'(BUSY);
    end
    check("pause_busy_cycles", busy_cnt, 6);
    check("pause_final_q", int'(Q), 8'h0F);
    check("pause_done", int'(DONE), 1);

    // Rotate-left burst of 3 from 81.
    drive(3'b000, 1'b0, 8'h00, 1'b0, '0, 1'b1); step();
    drive(3'b010, 1'b0, 8'h81, 1'b0, '0, 1'b1); step();
    drive(3'b101, 1'b0, 8'h00, 1'b1, 4'd3, 1'b1); step();
    check("rol_accept_q", int'(Q), 8'h81);
    busy_cnt = int'(BUSY);
    for (int i = 0; i < 3; i++) begin
      drive(3'b000, 1'b0, 8'h00, 1'b0, '0, 1'b1);
      step();
      check_model("rol");
      busy_cnt += int'(BUSY);
    end
    check("rol_busy_cycles", busy_cnt, ROT ? 3 : 0);
    check("rol_final_q", int'(Q), ROT ? 8'h0C : 8'h81);
    check("rol_done", int'(DONE), ROT ? 1 : 0);
    step();

    // Asynchronous reset in the middle of a LEN=5 burst.
    drive(3'b010, 1'b0, 8'hA5, 1'b0, '0, 1'b1); step();
    drive(3'b001, 1'b1, 8'h00, 1'b1, 4'd5, 1'b1); step();
    drive(3'b001, 1'b1, 8'h00, 1'b0, '0, 1'b1); step(); step();
    check("midburst_busy", int'(BUSY), 1);
    #2 RESET_N = 1'b0;
    #1;
    check("rst_mid_q", int'(Q), 0);
    check("rst_mid_busy", int'(BUSY), 0);
    check("rst_mid_done", int'(DONE), 0);
    model_reset();
    RESET_N = 1'b1;
    drive(3'b010, 1'b0, 8'h5A, 1'b0, '0, 1'b1); step();
    check("post_rst_q", int'(Q), 8'h5A);
    check("post_rst_busy", int'(BUSY), 0);
    drive(3'b000, 1'b1, 8'h00, 1'b0, '0, 1'b1); step();
    check_model("post_rst_hold");

    // Randomized traffic against the reference model.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 59) == 0) begin
        RESET_N = 1'b0;
        #1;
        model_reset();
        check_model("rand_rst");
        RESET_N = 1'b1;
      end
      drive(3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 8'($urandom),
            ($urandom_range(0, 2) == 0), CNT_W'($urandom_range(0, 12)),
            ($urandom_range(0, 3) != 0));
      step();
      check_model("rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
